// File: rtl/genetico_loader.sv
// Serial chromosome loader and truth-table sweeper for one genetico instance.
// Define GENETICO_LOADER_ABORT_EN to add the abort input.
module genetico_loader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
`ifdef GENETICO_LOADER_ABORT_EN
  input  logic            abort,
`endif
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            bit_ready,
  output logic [3:0][8:0] conf_les,
  output logic [1:0][2:0] conf_outs,
  output logic [1:0]      chrom_in,
  input  logic [1:0]      chrom_out,
  output logic [7:0]      result,
  output logic            res_valid,
  input  logic            res_ready
);

  localparam int CHROM_BITS = 42;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    EVAL,
    RESULT
  } state_e;

  state_e                  state_q;
  logic [5:0]              cnt_q;
  logic [SW-1:0]           settle_q;
  logic [1:0]              vec_q;
  logic [CHROM_BITS-1:0]   shadow_q;
  logic [CHROM_BITS-1:0]   shadow_d;
  logic [3:0][8:0]         les_q;
  logic [1:0][2:0]         outs_q;
  logic [7:0]              result_q;
  logic                    ready_q;
  logic                    valid_q;
  logic                    abort_w;

`ifdef GENETICO_LOADER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // First bit received ends up in the MSB after 42 shifts
  assign shadow_d = {shadow_q[CHROM_BITS-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      shadow_q <= '0;
      les_q    <= '0;
      outs_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else if (abort_w) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bit_valid && ready_q) begin
            shadow_q <= shadow_d;
            if (cnt_q == 6'(CHROM_BITS - 1)) begin
              les_q    <= shadow_d[CHROM_BITS-1:6];
              outs_q   <= shadow_d[5:0];
              cnt_q    <= '0;
              vec_q    <= '0;
              settle_q <= '0;
              result_q <= '0;
              ready_q  <= 1'b0;
              state_q  <= EVAL;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        EVAL: begin
          if (settle_q == SLAST) begin
            result_q[{vec_q, 1'b0} +: 2] <= chrom_out;
            settle_q <= '0;
            if (vec_q == 2'd3) begin
              valid_q <= 1'b1;
              state_q <= RESULT;
            end else begin
              vec_q <= vec_q + 2'd1;
            end
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bit_ready = ready_q;
  assign res_valid = valid_q;
  assign result    = result_q;
  assign conf_les  = les_q;
  assign conf_outs = outs_q;
  assign chrom_in  = vec_q;

endmodule

// File: doc/genetico_loader.md
# genetico_loader

Configuration loader and truth-table evaluator for the `genetico` evolvable circuit. It receives a serial chromosome from the GA host and commits it to the circuit's configuration inputs. It then sweeps every `chromIn` vector, captures `chromOut`, and returns the 8-bit truth table to the host over a valid/ready handshake. It sits between the GA host link and one `genetico` instance. It drives `conf_les`, `conf_outs` and `chromIn`, and reads `chromOut`.

## Interface
- `SETTLE_CYCLES`, 2: cycles each input vector is held before sampling; minimum 1.
- `CHROM_BITS`, 42: chromosome length, 4×9 LE bits plus 2×3 output-select bits; fixed.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `bit_in`  in  1  serial chromosome bit
- `bit_valid`  in  1  `bit_in` is valid
- `bit_ready`  out  1  loader accepts a bit this cycle
- `conf_les`  out  [3:0][8:0]  committed LE configuration, driven to `genetico`
- `conf_outs`  out  [1:0][2:0]  committed output selects, driven to `genetico`
- `chrom_in`  out  2  test vector, driven to `genetico` `chromIn`
- `chrom_out`  in  2  from `genetico` `chromOut`
- `result`  out  8  truth table
- `res_valid`  out  1  `result` is valid
- `res_ready`  in  1  host accepts `result`

## Operation
- A bit transfers when `bit_valid && bit_ready`. Each accepted bit shifts into a 42-bit shadow register from the LSB end, so the first bit lands in shadow[41].
- Shadow packing:
  - [41:33] = LE3, [32:24] = LE2, [23:15] = LE1, [14:6] = LE0.
  - [5:3] = `conf_outs[1]`, [2:0] = `conf_outs[0]`.
- FSM has three states: LOAD, EVAL and RESULT.
- **LOAD**
  - `bit_ready`=1.
  - A 6-bit counter counts accepted bits.
  - On the 42nd accepted bit, the shadow (including that bit) is copied to `conf_les`/`conf_outs`, the counter clears, `vec_idx`=0, and the FSM goes to EVAL.
- **EVAL**
  - `bit_ready`=0. `chrom_in`=`vec_idx`.
  - A settle counter runs from 0 to `SETTLE_CYCLES`-1.
  - On the last settle cycle, `chrom_out` is written to `result[2*vec_idx+1 : 2*vec_idx]`.
  - After the write, `vec_idx` increments. When `vec_idx` was 3, the FSM goes to RESULT instead.
- **RESULT**
  - `res_valid`=1; `result` and the configuration outputs are held stable.
  - On `res_valid && res_ready`, the FSM returns to LOAD.
- `conf_les`/`conf_outs` change only at commit and at reset. They stay applied after evaluation so the host can probe the circuit.
- The configuration may create combinational loops among LEs. `SETTLE_CYCLES` is the only settling guarantee, and the block does not detect oscillation.
- `result` is cleared to 0 at each commit.
- Bits presented while `bit_ready`=0 are ignored and not consumed.

## Timing
- All outputs are registered.
- Reset values:
  - `bit_ready`=1, `res_valid`=0.
  - `conf_les`=0, `conf_outs`=0, `chrom_in`=0, `result`=0.
  - State is LOAD, all counters are 0, shadow is 0.
- Reset mid-operation, in any state, discards the partial chromosome and the pending result and returns to the reset values on the next cycle.
- Let cycle t be the cycle in which the final bit is accepted:
  - At t+1: new configuration visible, `bit_ready`=0, `chrom_in`=0.
  - Vector i is applied during cycles t+1+i·S … t+(i+1)·S, where S=`SETTLE_CYCLES`.
  - `res_valid` rises at t+1+4·S, which is t+9 for the default S.
- If the handshake completes in cycle r, then at r+1 `res_valid`=0 and `bit_ready`=1.
- Maximum bit throughput is 1 bit per cycle. `bit_valid` may be gapped arbitrarily.

## Configuration
- Macro `GENETICO_LOADER_ABORT_EN`.
- **Defined:**
  - Adds input port `abort` (1 bit).
  - `abort`=1 in any state goes to LOAD next cycle and clears the bit counter, shadow, `result` and `res_valid`.
  - `conf_les`/`conf_outs` keep their last committed value.
  - `abort` takes priority over a simultaneous bit acceptance or result handshake.
- **Undefined:** no `abort` port; the only way back to LOAD is a completed result handshake or `reset`.

## Test plan
The bench instantiates a real `genetico` as the load. Test 1 checks reset values; Test 3 runs with S=3, all others with S=2.
1. Hold reset 3 cycles, release → `bit_ready`=1, `res_valid`=0, all configuration outputs, `chrom_in` and `result` = 0.
2. Send 36 zeros, then 0,0,1,0,0,0 (`conf_outs` = {1,0}) back-to-back → `conf_outs[1]`=1, `conf_outs[0]`=0 at t+1; `res_valid` at t+9; `result`=8'hE4.
3. Set `SETTLE_CYCLES`=3. Send 36 zeros, then 0,0,0,0,0,1 (`conf_outs` = {0,1}) → `result`=8'hD8 at t+13.
4. Repeat test 2 with `bit_valid` asserted every third cycle, and hold `res_ready` low for 10 cycles → `result` stays 8'hE4 and stable, `bit_ready`=0 throughout; after the handshake `bit_ready`=1 on the next cycle.
5. Assert reset after 20 accepted bits → reset values next cycle; a following full load of the test 2 stream gives `result`=8'hE4.
6. With `GENETICO_LOADER_ABORT_EN`: assert `abort` after 30 bits, then send the test 3 stream → `result`=8'hD8, with `conf_les`/`conf_outs` unchanged between the abort and the commit.
